// File: rtl/ldpc_3gpp_dec_vnode_p_engine_pkg.sv
// Shared types and saturation helpers for the layered 3GPP LDPC decoder node engines.
package ldpc_3gpp_dec_vnode_p_engine_pkg;

  localparam int unsigned cCOL_BY_CYCLE = 4;
  localparam int unsigned cSAT_CNT_W    = 16;

  typedef struct packed {
    logic sof;
    logic sop;
    logic eop;
    logic eof;
  } strb_t;

  // Symmetric clip to +/-(2^(w-1)-1); the most-negative code is never returned.
  function automatic int sat_node(input int x, input int unsigned w);
    int lim;
    lim = (1 << (w - 1)) - 1;
    if (x > lim)
      return lim;
    else if (x < -lim)
      return -lim;
    else
      return x;
  endfunction

  function automatic int add_sat(input int a, input int b, input int unsigned w);
    return sat_node(a + b, w);
  endfunction

endpackage

// File: rtl/ldpc_3gpp_dec_vnode_p_engine_fifo.sv
// Vnode hold buffer: synchronous FIFO with combinational head read and error pulses.
module ldpc_3gpp_dec_vnode_fifo #(
  parameter int unsigned pW     = 8,
  parameter int unsigned pDEPTH = 16
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        clkena,
  input  logic                        push,
  input  logic                        pop,
  input  logic [pW-1:0]               wdata,
  output logic [pW-1:0]               head,
  output logic [$clog2(pDEPTH):0]     count,
  output logic                        empty,
  output logic                        ovf,
  output logic                        udf
);

  localparam int unsigned cAW = $clog2(pDEPTH);

  logic [pW-1:0]  mem [pDEPTH];
  logic [cAW-1:0] wptr;
  logic [cAW-1:0] rptr;
  logic           full;
  logic           do_push;
  logic           do_pop;

  assign empty = (count == '0);
  assign full  = (count == (cAW + 1)'(pDEPTH));
  assign head  = mem[rptr];

  // A pop on the same edge frees the slot, so a full FIFO still accepts the push.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign ovf     = push & full & ~do_pop;
  assign udf     = pop & empty;

  always_ff @(posedge clk) begin
    if (clkena) begin
      if (!reset_n) begin
        wptr  <= '0;
        rptr  <= '0;
        count <= '0;
      end else begin
        if (do_push)
          wptr <= wptr + 1'b1;
        if (do_pop)
          rptr <= rptr + 1'b1;
        case ({do_push, do_pop})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (clkena && reset_n && do_push)
      mem[wptr] <= wdata;
  end

endmodule

// File: rtl/ldpc_3gpp_dec_vnode_p_engine.sv
// Variable-node stage: extrinsic vnode forward path, vnode hold FIFO, LLR write-back.
// Optional saturation event counter enabled by LDPC_3GPP_DEC_VNODE_SAT_CNT_EN.
module ldpc_3gpp_dec_vnode_p_engine
  import ldpc_3gpp_dec_vnode_p_engine_pkg::*;
#(
  parameter int unsigned pNODE_W     = 5,
  parameter int unsigned pFIFO_DEPTH = 16
) (
  input  logic                                   iclk,
  input  logic                                   ireset,
  input  logic                                   iclkena,
  input  logic                                   ival,
  input  strb_t                                  istrb,
  input  logic [cCOL_BY_CYCLE-1:0][pNODE_W-1:0]  illr,
  input  logic [cCOL_BY_CYCLE-1:0][pNODE_W-1:0]  icnode_old,
  input  logic [cCOL_BY_CYCLE-1:0]               ivmask,
  output logic                                   ordy,
  output logic                                   oval,
  output strb_t                                  ostrb,
  output logic [cCOL_BY_CYCLE-1:0][pNODE_W-1:0]  ovnode,
  output logic [cCOL_BY_CYCLE-1:0]               ovmask,
  input  logic                                   icval,
  input  logic [cCOL_BY_CYCLE-1:0][pNODE_W-1:0]  icnode,
  output logic                                   owval,
  output strb_t                                  owstrb,
  output logic [cCOL_BY_CYCLE-1:0][pNODE_W-1:0]  owllr,
  output logic                                   oerr,
  output logic [cSAT_CNT_W-1:0]                  osat_cnt
);

  localparam int unsigned cCNT_W = $clog2(pFIFO_DEPTH) + 1;
  localparam int unsigned cENT_W = cCOL_BY_CYCLE * pNODE_W + cCOL_BY_CYCLE + $bits(strb_t);

  typedef logic [cCOL_BY_CYCLE-1:0][pNODE_W-1:0] word_t;

  function automatic int sx(input logic [pNODE_W-1:0] x);
    return int'(signed'(x));
  endfunction

  word_t                    fwd_vnode;
  word_t                    push_vnode;
  word_t                    wb_llr;
  word_t                    head_vnode;
  logic [cCOL_BY_CYCLE-1:0] head_mask;
  strb_t                    head_strb;
  logic [cENT_W-1:0]        head;
  logic [cCNT_W-1:0]        count;
  logic                     empty;
  logic                     ovf;
  logic                     udf;
  logic                     pop_ok;

  assign {head_vnode, head_mask, head_strb} = head;
  assign pop_ok = icval & ~empty;
  assign ordy   = ({1'b0, count} + {{cCNT_W{1'b0}}, oval}) <= (cCNT_W + 1)'(pFIFO_DEPTH - 2);

  // Masked columns send 0 downstream but keep the raw LLR for write-back.
  always_comb begin
    fwd_vnode  = '0;
    push_vnode = '0;
    wb_llr     = '0;
    for (int unsigned i = 0; i < cCOL_BY_CYCLE; i++) begin
      if (ivmask[i]) begin
        push_vnode[i] = illr[i];
      end else begin
        fwd_vnode[i]  = pNODE_W'(sat_node(sx(illr[i]) - sx(icnode_old[i]), pNODE_W));
        push_vnode[i] = fwd_vnode[i];
      end
      if (head_mask[i])
        wb_llr[i] = head_vnode[i];
      else
        wb_llr[i] = pNODE_W'(add_sat(sx(head_vnode[i]), sx(icnode[i]), pNODE_W));
    end
  end

  ldpc_3gpp_dec_vnode_fifo #(
    .pW     (cENT_W),
    .pDEPTH (pFIFO_DEPTH)
  ) u_fifo (
    .clk     (iclk),
    .reset_n (ireset),
    .clkena  (iclkena),
    .push    (ival),
    .pop     (icval),
    .wdata   ({push_vnode, ivmask, istrb}),
    .head    (head),
    .count   (count),
    .empty   (empty),
    .ovf     (ovf),
    .udf     (udf)
  );

  always_ff @(posedge iclk) begin
    if (iclkena) begin
      if (!ireset) begin
        oval  <= 1'b0;
        owval <= 1'b0;
        oerr  <= 1'b0;
      end else begin
        oval  <= ival;
        owval <= pop_ok;
        oerr  <= oerr | ovf | udf;
        if (ival) begin
          ostrb  <= istrb;
          ovnode <= fwd_vnode;
          ovmask <= ivmask;
        end
        if (pop_ok) begin
          owstrb <= head_strb;
          owllr  <= wb_llr;
        end
      end
    end
  end

`ifdef LDPC_3GPP_DEC_VNODE_SAT_CNT_EN
  logic [cCOL_BY_CYCLE-1:0] fwd_clip;
  logic [cCOL_BY_CYCLE-1:0] wb_clip;
  logic [cSAT_CNT_W:0]      sat_sum;
  logic [cSAT_CNT_W-1:0]    sat_next;

  always_comb begin
    fwd_clip = '0;
    wb_clip  = '0;
    for (int unsigned i = 0; i < cCOL_BY_CYCLE; i++) begin
      fwd_clip[i] = ival & ~ivmask[i] &
                    (sat_node(sx(illr[i]) - sx(icnode_old[i]), pNODE_W) != sx(illr[i]) - sx(icnode_old[i]));
      wb_clip[i]  = pop_ok & ~head_mask[i] &
                    (add_sat(sx(head_vnode[i]), sx(icnode[i]), pNODE_W) != sx(head_vnode[i]) + sx(icnode[i]));
    end
    // Clear on frame start happens before this cycle's events are added.
    sat_sum  = {1'b0, ((ival && istrb.sof && istrb.sop) ? '0 : osat_cnt)} +
               (cSAT_CNT_W + 1)'($countones(fwd_clip) + $countones(wb_clip));
    sat_next = sat_sum[cSAT_CNT_W] ? '1 : sat_sum[cSAT_CNT_W-1:0];
  end

  always_ff @(posedge iclk) begin
    if (iclkena) begin
      if (!ireset)
        osat_cnt <= '0;
      else
        osat_cnt <= sat_next;
    end
  end
`else
  assign osat_cnt = '0;
`endif

endmodule

// File: tb/tb_ldpc_3gpp_dec_vnode_p_engine.sv
// Self-checking bench: directed test-plan steps then randomized traffic against a queue model.
module tb_ldpc_3gpp_dec_vnode_p_engine;
  import ldpc_3gpp_dec_vnode_p_engine_pkg::*;

  localparam int W = 5;
  localparam int D = 4;
  localparam int C = cCOL_BY_CYCLE;

  typedef struct packed {
    logic [C-1:0][W-1:0] v;
    logic [C-1:0]        m;
    strb_t               s;
  } ent_t;

  logic                iclk, ireset, iclkena, ival, icval;
  strb_t               istrb, ostrb, owstrb;
  logic [C-1:0][W-1:0] illr, icnode_old, icnode, ovnode, owllr;
  logic [C-1:0]        ivmask, ovmask;
  logic                ordy, oval, owval, oerr;
  logic [15:0]         osat_cnt;

  ldpc_3gpp_dec_vnode_p_engine #(
    .pNODE_W     (W),
    .pFIFO_DEPTH (D)
  ) dut (
    .iclk       (iclk),
    .ireset     (ireset),
    .iclkena    (iclkena),
    .ival       (ival),
    .istrb      (istrb),
    .illr       (illr),
    .icnode_old (icnode_old),
    .ivmask     (ivmask),
    .ordy       (ordy),
    .oval       (oval),
    .ostrb      (ostrb),
    .ovnode     (ovnode),
    .ovmask     (ovmask),
    .icval      (icval),
    .icnode     (icnode),
    .owval      (owval),
    .owstrb     (owstrb),
    .owllr      (owllr),
    .oerr       (oerr),
    .osat_cnt   (osat_cnt)
  );

  initial iclk = 1'b0;
  always #5 iclk = ~iclk;

  int errors = 0;
  int checks = 0;

  ent_t                q[$];
  logic                e_oval = 0, e_owval = 0, e_oerr = 0;
  logic [C-1:0][W-1:0] e_ovnode, e_owllr;
  logic [C-1:0]        e_ovmask;
  strb_t               e_ostrb, e_owstrb;
  int                  e_sat = 0;

  function automatic int sx(input logic [W-1:0] x);
    return int'(signed'(x));
  endfunction

  function automatic int clip(input int v);
    if (v > 15) return 15;
    if (v < -15) return -15;
    return v;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: advance the reference model on the edge, then compare all outputs.
  task automatic tick();
    ent_t e;
    int   r;
    int   ev;
    @(posedge iclk);
    if (iclkena) begin
      if (!ireset) begin
        q.delete();
        e_oval = 0; e_owval = 0; e_oerr = 0; e_sat = 0;
      end else begin
        ev = 0;
        if (ival && istrb.sof && istrb.sop) e_sat = 0;
        e_owval = 0;
        if (icval) begin
          if (q.size() == 0) e_oerr = 1;
          else begin
            e = q.pop_front();
            e_owval = 1;
            e_owstrb = e.s;
            for (int c = 0; c < C; c++) begin
              if (e.m[c]) e_owllr[c] = e.v[c];
              else begin
                r = sx(e.v[c]) + sx(icnode[c]);
                if (clip(r) != r) ev++;
                e_owllr[c] = W'(clip(r));
              end
            end
          end
        end
        e_oval = ival;
        if (ival) begin
          for (int c = 0; c < C; c++) begin
            if (ivmask[c]) begin
              e_ovnode[c] = '0;
              e.v[c] = illr[c];
            end else begin
              r = sx(illr[c]) - sx(icnode_old[c]);
              if (clip(r) != r) ev++;
              e_ovnode[c] = W'(clip(r));
              e.v[c] = W'(clip(r));
            end
          end
          e.m = ivmask; e.s = istrb;
          e_ovmask = ivmask; e_ostrb = istrb;
          if (q.size() < D) q.push_back(e);
          else e_oerr = 1;
        end
`ifdef LDPC_3GPP_DEC_VNODE_SAT_CNT_EN
        e_sat = (e_sat + ev > 65535) ? 65535 : e_sat + ev;
`endif
      end
    end
    #1;
    chk("oval", oval, e_oval);
    chk("owval", owval, e_owval);
    chk("oerr", oerr, e_oerr);
    chk("ordy", ordy, (q.size() + int'(e_oval)) <= D - 2);
    chk("osat_cnt", osat_cnt, e_sat[15:0]);
    if (e_oval) begin
      chk("ovnode", ovnode, e_ovnode);
      chk("ovmask", ovmask, e_ovmask);
      chk("ostrb", ostrb, e_ostrb);
    end
    if (e_owval) begin
      chk("owllr", owllr, e_owllr);
      chk("owstrb", owstrb, e_owstrb);
    end
  endtask

  task automatic rnd_data();
    for (int c = 0; c < C; c++) begin
      illr[c] = W'($urandom_range(0, 31));
      icnode_old[c] = W'($urandom_range(0, 31));
      icnode[c] = W'($urandom_range(0, 31));
    end
  endtask

  task automatic idle();
    ival = 0; icval = 0; ivmask = '0; istrb = '0;
    rnd_data();
  endtask

  task automatic drain();
    ival = 0;
    for (int k = 0; k < 2 * D && q.size() > 0; k++) begin
      icval = 1; rnd_data(); tick();
    end
    icval = 0;
  endtask

  task automatic do_reset();
    idle(); ireset = 0; tick(); ireset = 1;
  endtask

  initial begin
    iclkena = 1; ireset = 0; idle();
    tick(); tick();
    ireset = 1;
    chk("reset_ordy", ordy, 1'b1);
    chk("reset_oerr", oerr, 1'b0);

    // Forward saturation: 10 - (-8) clips to 15.
    idle(); ival = 1; istrb = '{sof: 1, sop: 1, eop: 0, eof: 0};
    illr[0] = 5'd10; icnode_old[0] = 5'b11000;
    for (int c = 1; c < C; c++) begin illr[c] = 5'd1; icnode_old[c] = 5'd1; end
    tick();
    chk("fwd_sat_col0", ovnode[0], 5'd15);
`ifdef LDPC_3GPP_DEC_VNODE_SAT_CNT_EN
    chk("fwd_sat_cnt", osat_cnt, 16'd1);
`endif
    idle(); drain();

    // Round trip: 3 - 5 = -2, then -2 + -4 = -6 with original strobes.
    idle(); ival = 1; istrb = '{sof: 0, sop: 1, eop: 1, eof: 0};
    illr[0] = 5'd3; icnode_old[0] = 5'd5;
    tick();
    chk("rt_ovnode", ovnode[0], 5'b11110);
    idle(); icval = 1; icnode[0] = 5'b11100;
    tick();
    chk("rt_owllr", owllr[0], 5'b11010);
    chk("rt_owstrb", owstrb, 4'b0110);
    idle(); tick();

    // Masked column passes the raw LLR through the hold buffer.
    idle(); ival = 1; ivmask = 4'b0001; illr[0] = 5'b11001;
    tick();
    chk("mask_ovnode", ovnode[0], 5'd0);
    chk("mask_ovmask", ovmask[0], 1'b1);
    idle(); icval = 1; icnode[0] = 5'd9;
    tick();
    chk("mask_owllr", owllr[0], 5'b11001);
    idle(); tick();

    // Full: five pushes with no pops, then five pops.
    for (int k = 0; k < 5; k++) begin
      idle(); ival = 1; istrb = strb_t'(4'(k));
      tick();
      if (k == 1) chk("full_ordy_low", ordy, 1'b0);
    end
    chk("full_oerr", oerr, 1'b1);
    for (int k = 0; k < 4; k++) begin
      idle(); icval = 1; tick();
      chk("full_pop_order", owstrb, 4'(k));
    end
    idle(); icval = 1; tick();
    chk("empty_pop_owval", owval, 1'b0);
    do_reset();

    // Simultaneous push/pop at count 3.
    for (int k = 0; k < 3; k++) begin
      idle(); ival = 1; istrb = strb_t'(4'(k)); tick();
    end
    for (int k = 0; k < 8; k++) begin
      idle(); ival = 1; icval = 1; istrb = strb_t'(4'(k + 3)); tick();
      chk("simul_order", owstrb, 4'(k));
    end
    chk("simul_oerr", oerr, 1'b0);
    idle(); drain();

    // Reset in the middle of traffic.
    for (int k = 0; k < 3; k++) begin
      idle(); ival = 1; tick();
    end
    idle(); ireset = 0; tick(); ireset = 1;
    chk("midrst_oval", oval, 1'b0);
    chk("midrst_owval", owval, 1'b0);
    chk("midrst_ordy", ordy, 1'b1);
    chk("midrst_oerr", oerr, 1'b0);
    idle(); icval = 1; tick();
    chk("midrst_underflow", oerr, 1'b1);
    do_reset();

    // Randomized traffic with clock-enable stalls and occasional resets.
    for (int k = 0; k < 400; k++) begin
      rnd_data();
      iclkena = ($urandom_range(0, 9) != 0);
      ireset = ($urandom_range(0, 99) != 0);
      ival = ordy ? ($urandom_range(0, 9) < 7) : ($urandom_range(0, 19) == 0);
      icval = (q.size() > 0) ? ($urandom_range(0, 9) < 6) : ($urandom_range(0, 29) == 0);
      ivmask = C'($urandom_range(0, (1 << C) - 1)) & C'($urandom_range(0, (1 << C) - 1));
      istrb = strb_t'(4'($urandom_range(0, 15)));
      tick();
    end
    iclkena = 1; ireset = 1; idle(); drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
